// File: rtl/ram_3d_stream_reader.sv
// Read-side master for the banked feature-map RAM. Walks an address window on
// port B of every bank in lockstep, absorbs the one-cycle read latency in a
// two-entry skid FIFO and presents each all-bank word as a valid/ready beat.
module ram_3d_stream_reader #(
  parameter int RAM_NUM = 16,
  parameter int WIDTH   = 16,
  parameter int ADDRESS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDRESS-1:0] base_addr,
  input  logic [ADDRESS:0]   len,
  output logic               enb,
  output logic               web,
  output logic [ADDRESS-1:0] addrb  [0:RAM_NUM-1],
  input  logic [WIDTH-1:0]   doutb  [0:RAM_NUM-1],
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data [0:RAM_NUM-1],
  output logic               m_last,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [ADDRESS-1:0] addr_ptr;
  logic [ADDRESS:0]   issue_cnt;
  logic [ADDRESS:0]   beat_cnt;
  logic               inflight;
  logic [1:0]         fifo_count;
  logic               wr_ptr, rd_ptr;
  logic [WIDTH-1:0]   fifo_mem [0:1][0:RAM_NUM-1];
  logic               pop, launch, zero_launch;
  logic [2:0]         occupancy;

  assign pop         = m_valid & m_ready;
  assign launch      = (state == IDLE) & start & (len != '0);
  assign zero_launch = (state == IDLE) & start & (len == '0);

  // Reads already committed (queued or in the RAM pipe) once this cycle's pop
  // leaves; a new read is only issued if it still fits in the two-entry FIFO.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign enb       = (state == RUN) && (issue_cnt != '0) && (occupancy < 3'd2);
  assign web       = 1'b0;

  assign m_valid = (fifo_count != 2'd0);
  assign m_last  = m_valid && (beat_cnt == (ADDRESS+1)'(1));
  assign busy    = (state != IDLE);

  // Fan the shared address out to every bank and expose the FIFO head.
  always_comb begin
    for (int i = 0; i < RAM_NUM; i++) begin
      addrb[i]  = addr_ptr;
      m_data[i] = fifo_mem[rd_ptr][i];
    end
  end

  // Next-state logic for the window sequencer.
  // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (enb && issue_cnt == (ADDRESS+1)'(1)) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Address pointer, issue/beat counters, read-in-flight flag and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_ptr  <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      inflight <= enb;
      done     <= (pop & m_last) | zero_launch;
      if (launch) begin
        addr_ptr  <= base_addr;
        issue_cnt <= len;
        beat_cnt  <= len;
      end else begin
        if (enb) begin
          addr_ptr  <= addr_ptr + ADDRESS'(1);
          issue_cnt <= issue_cnt - (ADDRESS+1)'(1);
        end
        if (pop) beat_cnt <= beat_cnt - (ADDRESS+1)'(1);
      end
    end
  end

  // Two-entry FIFO: captures returning read data, releases the head on pop.
  // NOTE: the storage is reset too, so m_data reads zero out of reset and after an abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      for (int e = 0; e < 2; e++)
        for (int i = 0; i < RAM_NUM; i++)
          fifo_mem[e][i] <= '0;
    end else begin
      if (inflight) begin
        for (int i = 0; i < RAM_NUM; i++) fifo_mem[wr_ptr][i] <= doutb[i];
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({inflight, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The issue throttle guarantees a capture never lands on a full FIFO.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(inflight && !pop && fifo_count == 2'd2))
        else $fatal(1, "ram_3d_stream_reader: fifo overflow");
    end
  end

endmodule

// File: tb/tb_ram_3d_stream_reader.sv
// Self-checking bench for ram_3d_stream_reader: a registered-read RAM model,
// randomized windows and backpressure, and a window-level reference model.
module tb_ram_3d_stream_reader;

  localparam int RAM_NUM = 16;
  localparam int WIDTH   = 16;
  localparam int ADDRESS = 10;
  localparam int DEPTH   = 1 << ADDRESS;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDRESS-1:0] base_addr;
  logic [ADDRESS:0]   len;
  logic               enb, web;
  logic [ADDRESS-1:0] addrb  [0:RAM_NUM-1];
  logic [WIDTH-1:0]   doutb  [0:RAM_NUM-1];
  logic               m_valid, m_ready, m_last, busy, done;
  logic [WIDTH-1:0]   m_data [0:RAM_NUM-1];

  logic [WIDTH-1:0]   ram [0:RAM_NUM-1][0:DEPTH-1];

  int n_assert = 0;
  int n_fail   = 0;

  ram_3d_stream_reader #(.RAM_NUM(RAM_NUM), .WIDTH(WIDTH), .ADDRESS(ADDRESS)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .enb(enb), .web(web), .addrb(addrb), .doutb(doutb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Banked RAM port B: registered read, data valid the cycle after enb.
  always @(posedge clk) begin
    if (enb)
      for (int i = 0; i < RAM_NUM; i++) doutb[i] <= ram[i][addrb[i]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < RAM_NUM; i++) acc = acc | 32'(m_data[i]) | 32'(addrb[i]);
    check({tag, "_lanes"}, acc, 0);
    check({tag, "_enb"}, 32'(enb), 0);
    check({tag, "_web"}, 32'(web), 0);
    check({tag, "_valid"}, 32'(m_valid), 0);
    check({tag, "_last"}, 32'(m_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // Runs one window. Entered and left at posedge+1; the return cycle is the
  // done cycle, so an immediate next call starts back-to-back.
  task automatic run_window(input int base, input int n, input int pct);
    int issued, popped, last_pop_c, c;
    bit prev_stall, ok;
    logic [WIDTH-1:0] prev_data [0:RAM_NUM-1];
    issued = 0; popped = 0; last_pop_c = 0; prev_stall = 0;
    start     = 1'b1;
    base_addr = ADDRESS'(base);
    len       = (ADDRESS+1)'(n);
    m_ready   = ($urandom_range(99) < pct);
    @(negedge clk);
    check("c0_enb", 32'(enb), 0);
    check("c0_valid", 32'(m_valid), 0);
    check("c0_busy", 32'(busy), 0);
    for (c = 1; c <= 20 * n + 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        check("done_cycle", c, (n == 0) ? 1 : last_pop_c + 1);
        check("done_beats", popped, n);
        check("done_issued", issued, n);
        check("done_busy", 32'(busy), 0);
        return;
      end
      m_ready = ($urandom_range(99) < pct);
      @(negedge clk);
      check("web", 32'(web), 0);
      check("busy", 32'(busy), 32'(n != 0));
      ok = 1;
      for (int i = 1; i < RAM_NUM; i++) if (addrb[i] !== addrb[0]) ok = 0;
      check("addr_lanes", 32'(ok), 1);
      if (enb) begin
        check("addr", 32'(addrb[0]), (base + issued) % DEPTH);
        issued++;
        check("over_issue", 32'(issued <= n), 1);
      end
      if (m_valid) begin
        if (prev_stall) begin
          ok = 1;
          for (int i = 0; i < RAM_NUM; i++) if (m_data[i] !== prev_data[i]) ok = 0;
          check("stall_stable", 32'(ok), 1);
        end
        ok = 1;
        for (int i = 0; i < RAM_NUM; i++)
          if (32'(m_data[i]) !== i * 1024 + (base + popped) % DEPTH) ok = 0;
        check("beat_data", 32'(ok), 1);
        check("beat_last", 32'(m_last), 32'(popped == n - 1));
      end else begin
        check("idle_last", 32'(m_last), 0);
      end
      if (prev_stall) check("stall_valid", 32'(m_valid), 1);
      prev_stall = m_valid & ~m_ready;
      for (int i = 0; i < RAM_NUM; i++) prev_data[i] = m_data[i];
      if (m_valid && m_ready) begin
        if (pct == 100) check("beat_cycle", c, popped + 3);
        popped++;
        last_pop_c = c;
      end
      check("outstanding", 32'(issued - popped <= 2), 1);
    end
    check("window_timeout", 0, 1);
  endtask

  initial begin
    int pops;
    for (int b = 0; b < RAM_NUM; b++)
      for (int a = 0; a < DEPTH; a++) ram[b][a] = WIDTH'(b * 1024 + a);
    rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    #1;
    check_all_zero("reset");
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    run_window(0, 4, 100);       // basic window, full throughput
    run_window(1022, 4, 100);    // address wrap
    run_window(300, 8, 50);      // backpressure
    run_window(17, 0, 100);      // zero length
    run_window(5, 1024, 100);    // max length
    run_window(900, 6, 100);     // back-to-back start in done cycle
    for (int k = 0; k < 6; k++)
      run_window($urandom_range(DEPTH - 1), $urandom_range(1, 40), $urandom_range(30, 90));

    // Abort a window after its third beat with an asynchronous reset.
    start = 1'b1; base_addr = ADDRESS'(100); len = (ADDRESS+1)'(8); m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pops = 0;
    for (int i = 0; i < 20 && pops < 3; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) pops++;
    end
    check("abort_pops", pops, 3);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_all_zero("abort");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_abort_done", 32'(done), 0);
      check("post_abort_busy", 32'(busy), 0);
    end
    run_window(500, 6, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
